// File: rtl/ula_scheduler_pkg.sv
// Shared definitions for the ULA scheduler: ULA control codes, FSM encoding, default width.
package ula_scheduler_pkg;

  localparam int W_DEF = 16;

  typedef enum logic [2:0] {
    ULA_AND = 3'b000,
    ULA_OR  = 3'b001,
    ULA_ADD = 3'b010,
    ULA_NOR = 3'b011,
    ULA_SLL = 3'b100,
    ULA_SRL = 3'b101,
    ULA_SUB = 3'b110,
    ULA_SLT = 3'b111
  } ula_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } sched_state_e;

endpackage

// File: rtl/ula_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter: on a tie the port that did not win last time is granted.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  assign gnt_o[0] = req_i[0] & (~req_i[1] |  last_i);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);

endmodule

// File: rtl/ula_scheduler.sv
// Shares one external 16-bit ULA between two requesters: arbitrate, latch operands,
// capture ULAResult/Z one cycle later and return them over a valid/ready response.
module ula_scheduler
  import ula_scheduler_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid_i,
  output logic [1:0]   req_ready_o,
  input  logic [W-1:0] req_srcA0_i,
  input  logic [W-1:0] req_srcB0_i,
  input  logic [W-1:0] req_srcA1_i,
  input  logic [W-1:0] req_srcB1_i,
  input  logic [2:0]   req_ctrl0_i,
  input  logic [2:0]   req_ctrl1_i,
  input  logic [4:0]   req_shamt0_i,
  input  logic [4:0]   req_shamt1_i,
  output logic [1:0]   rsp_valid_o,
  input  logic [1:0]   rsp_ready_i,
  output logic [W-1:0] rsp_result_o,
  output logic         rsp_z_o,
  output logic [W-1:0] ula_srcA_o,
  output logic [W-1:0] ula_srcB_o,
  output logic [2:0]   ula_ctrl_o,
  output logic [4:0]   ula_shamt_o,
  input  logic [W-1:0] ula_result_i,
  input  logic         ula_z_i
);

  sched_state_e state_q;
  logic         owner_q, last_q;
  logic [W-1:0] srca_q, srcb_q, result_q;
  logic [2:0]   ctrl_q;
  logic [4:0]   shamt_q;
  logic         z_q;
  logic [1:0]   rsp_valid_q;

  logic [1:0]   gnt;
  logic [W-1:0] srca_d, srcb_d;
  logic [2:0]   ctrl_d;
  logic [4:0]   shamt_d;

  rr_arbiter2 u_arb (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  // Winner's payload; only sampled when a grant is issued in IDLE.
  assign srca_d  = gnt[1] ? req_srcA1_i  : req_srcA0_i;
  assign srcb_d  = gnt[1] ? req_srcB1_i  : req_srcB0_i;
  assign ctrl_d  = gnt[1] ? req_ctrl1_i  : req_ctrl0_i;
  assign shamt_d = gnt[1] ? req_shamt1_i : req_shamt0_i;

  // Gated by rst_n so ready drops the instant reset is asserted.
  assign req_ready_o = (state_q == ST_IDLE && rst_n) ? gnt : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      srca_q      <= '0;
      srcb_q      <= '0;
      ctrl_q      <= '0;
      shamt_q     <= '0;
      result_q    <= '0;
      z_q         <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            owner_q <= gnt[1];
            last_q  <= gnt[1];
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
            ctrl_q  <= ctrl_d;
            shamt_q <= shamt_d;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q    <= ula_result_i;
          z_q         <= ula_z_i;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i[owner_q]) begin
            rsp_valid_q <= 2'b00;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = result_q;
  assign rsp_z_o      = z_q;
  assign ula_srcA_o   = srca_q;
  assign ula_srcB_o   = srcb_q;
  assign ula_ctrl_o   = ctrl_q;
  assign ula_shamt_o  = shamt_q;

endmodule

// File: tb/tb_ula_scheduler.sv
// Directed bench for ula_scheduler with a behavioural ULA closing the loop.
module tb_ula_scheduler;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [W-1:0] srcA0, srcB0, srcA1, srcB1, rsp_result;
  logic [2:0]   ctrl0, ctrl1, ula_ctrl;
  logic [4:0]   shamt0, shamt1, ula_shamt;
  logic         rsp_z, ula_z;
  logic [W-1:0] ula_srcA, ula_srcB, ula_result;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ula_scheduler #(.W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_srcA0_i  (srcA0),
    .req_srcB0_i  (srcB0),
    .req_srcA1_i  (srcA1),
    .req_srcB1_i  (srcB1),
    .req_ctrl0_i  (ctrl0),
    .req_ctrl1_i  (ctrl1),
    .req_shamt0_i (shamt0),
    .req_shamt1_i (shamt1),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .rsp_z_o      (rsp_z),
    .ula_srcA_o   (ula_srcA),
    .ula_srcB_o   (ula_srcB),
    .ula_ctrl_o   (ula_ctrl),
    .ula_shamt_o  (ula_shamt),
    .ula_result_i (ula_result),
    .ula_z_i      (ula_z)
  );

  // External ULA model
  always_comb begin
    ula_result = '0;
    case (ula_ctrl)
      3'b000: ula_result = ula_srcA & ula_srcB;
      3'b001: ula_result = ula_srcA | ula_srcB;
      3'b010: ula_result = ula_srcA + ula_srcB;
      3'b011: ula_result = ~(ula_srcA | ula_srcB);
      3'b100: ula_result = ula_srcB << ula_shamt;
      3'b101: ula_result = ula_srcB >> ula_shamt;
      3'b110: ula_result = ula_srcA - ula_srcB;
      3'b111: ula_result = ($signed(ula_srcA) < $signed(ula_srcB)) ? 16'd1 : 16'd0;
      default: ula_result = '0;
    endcase
  end
  assign ula_z = (ula_result == '0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
    srcA0 = 16'h1234; srcB0 = 16'h5678; ctrl0 = 3'b010; shamt0 = 5'd3;
    srcA1 = 16'h1111; srcB1 = 16'h2222; ctrl1 = 3'b110; shamt1 = 5'd1;
    step(); step();
    chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
    chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("reset_result",    {16'd0, rsp_result}, 32'd0);
    chk("reset_z",         {31'd0, rsp_z}, 32'd0);
    chk("reset_ula_a",     {16'd0, ula_srcA}, 32'd0);
    chk("reset_ula_ctrl",  {29'd0, ula_ctrl}, 32'd0);
    req_valid = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_port0_add();
    srcA0 = 16'd3; srcB0 = 16'd4; ctrl0 = 3'b010; shamt0 = 5'd0;
    req_valid = 2'b01; rsp_ready = 2'b01;
    #1;
    chk("p0_accept_ready", {30'd0, req_ready}, 32'h1);
    step();
    req_valid = 2'b00;
    chk("p0_exec_ready",  {30'd0, req_ready}, 32'h0);
    chk("p0_exec_valid",  {30'd0, rsp_valid}, 32'h0);
    chk("p0_exec_ula_a",  {16'd0, ula_srcA}, 32'd3);
    chk("p0_exec_ula_b",  {16'd0, ula_srcB}, 32'd4);
    step();
    chk("p0_rsp_valid",   {30'd0, rsp_valid}, 32'h1);
    chk("p0_rsp_result",  {16'd0, rsp_result}, 32'd7);
    chk("p0_rsp_z",       {31'd0, rsp_z}, 32'd0);
    step();
    chk("p0_done_valid",  {30'd0, rsp_valid}, 32'h0);
  endtask

  task automatic test_port1_sub_slt();
    srcA1 = 16'd5; srcB1 = 16'd5; ctrl1 = 3'b110; shamt1 = 5'd0;
    req_valid = 2'b10; rsp_ready = 2'b10;
    #1;
    chk("p1_sub_ready", {30'd0, req_ready}, 32'h2);
    step(); req_valid = 2'b00;
    step();
    chk("p1_sub_valid",  {30'd0, rsp_valid}, 32'h2);
    chk("p1_sub_result", {16'd0, rsp_result}, 32'd0);
    chk("p1_sub_z",      {31'd0, rsp_z}, 32'd1);
    step();
    srcA1 = 16'd2; srcB1 = 16'd3; ctrl1 = 3'b111;
    req_valid = 2'b10;
    #1;
    chk("p1_slt_ready", {30'd0, req_ready}, 32'h2);
    step(); req_valid = 2'b00;
    chk("p1_slt_ctrl",  {29'd0, ula_ctrl}, 32'd7);
    step();
    chk("p1_slt_valid",  {30'd0, rsp_valid}, 32'h2);
    chk("p1_slt_result", {16'd0, rsp_result}, 32'd1);
    chk("p1_slt_z",      {31'd0, rsp_z}, 32'd0);
    step();
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    srcA0 = 16'd1; srcB0 = 16'd1; ctrl0 = 3'b010; shamt0 = 5'd0;
    srcA1 = 16'd0; srcB1 = 16'h0001; ctrl1 = 3'b100; shamt1 = 5'd4;
    req_valid = 2'b11; rsp_ready = 2'b11;
    @(negedge clk);
    chk("b2b_g0_ready", {30'd0, req_ready}, 32'h1);
    step(); step();
    chk("b2b_r0_valid",  {30'd0, rsp_valid}, 32'h1);
    chk("b2b_r0_result", {16'd0, rsp_result}, 32'h0002);
    step();
    chk("b2b_g1_ready", {30'd0, req_ready}, 32'h2);
    step(); step();
    chk("b2b_r1_valid",  {30'd0, rsp_valid}, 32'h2);
    chk("b2b_r1_result", {16'd0, rsp_result}, 32'h0010);
    step();
    chk("b2b_g2_ready", {30'd0, req_ready}, 32'h1);
    step(); step();
    chk("b2b_r2_valid",  {30'd0, rsp_valid}, 32'h1);
    chk("b2b_r2_result", {16'd0, rsp_result}, 32'h0002);
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_backpressure();
    // last grant was port 0 after the back-to-back run
    srcA0 = 16'hFFFF; srcB0 = 16'h0001; ctrl0 = 3'b010;
    req_valid = 2'b01; rsp_ready = 2'b00;
    step(); req_valid = 2'b11;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid",  {30'd0, rsp_valid}, 32'h1);
      chk("bp_result", {16'd0, rsp_result}, 32'h0);
      chk("bp_z",      {31'd0, rsp_z}, 32'd1);
      chk("bp_ready",  {30'd0, req_ready}, 32'h0);
      step();
    end
    rsp_ready = 2'b01;
    step();
    chk("bp_release_valid", {30'd0, rsp_valid}, 32'h0);
    chk("bp_next_grant",    {30'd0, req_ready}, 32'h2);
    req_valid = 2'b00;
    step();
    chk("drop_ready", {30'd0, req_ready}, 32'h0);
    chk("drop_valid", {30'd0, rsp_valid}, 32'h0);
    step();
    chk("drop_still_idle", {30'd0, rsp_valid}, 32'h0);
  endtask

  task automatic test_wrong_port_ready();
    srcA0 = 16'd6; srcB0 = 16'd3; ctrl0 = 3'b001;
    req_valid = 2'b01; rsp_ready = 2'b10;
    step(); req_valid = 2'b00;
    step();
    for (int i = 0; i < 2; i++) begin
      chk("wp_valid_held", {30'd0, rsp_valid}, 32'h1);
      chk("wp_result",     {16'd0, rsp_result}, 32'd7);
      step();
    end
    rsp_ready = 2'b01;
    step();
    chk("wp_done_valid", {30'd0, rsp_valid}, 32'h0);
  endtask

  task automatic test_reset_mid_exec();
    srcA1 = 16'h00F0; srcB1 = 16'h000F; ctrl1 = 3'b001;
    req_valid = 2'b10; rsp_ready = 2'b11;
    step(); req_valid = 2'b00;
    chk("rst_pre_ula_a", {16'd0, ula_srcA}, 32'h00F0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ula_a",  {16'd0, ula_srcA}, 32'h0);
    chk("rst_mid_ctrl",   {29'd0, ula_ctrl}, 32'h0);
    chk("rst_mid_valid",  {30'd0, rsp_valid}, 32'h0);
    chk("rst_mid_result", {16'd0, rsp_result}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_no_rsp", {30'd0, rsp_valid}, 32'h0);
    end
    srcA0 = 16'd9; srcB0 = 16'd9; ctrl0 = 3'b000;
    srcA1 = 16'd1; srcB1 = 16'd1; ctrl1 = 3'b010;
    req_valid = 2'b11;
    #1;
    chk("rst_tie_port0", {30'd0, req_ready}, 32'h1);
    step(); req_valid = 2'b00;
    step();
    chk("rst_after_valid",  {30'd0, rsp_valid}, 32'h1);
    chk("rst_after_result", {16'd0, rsp_result}, 32'd9);
    step();
  endtask

  initial begin
    test_reset();
    test_port0_add();
    test_port1_sub_slt();
    test_back_to_back();
    test_backpressure();
    test_wrong_port_ready();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
